// File: rtl/mips_defs.sv
// Shared MIPS decode definitions: opcode/funct constants and write-back enums.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_defs;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  // R-type funct codes (Instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [1:0] {WB_ALU, WB_DM, WB_EXT, WB_PC8} wb_src_t;
  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_kind_t;

  // R-type functs that produce a GPR result. jr, mult/div and mthi/mtlo
  // (and anything unrecognised) do not write the register file.
  function automatic logic rtype_writes(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
      FN_JALR, FN_MFHI, FN_MFLO,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: rtype_writes = 1'b1;
      default:                                        rtype_writes = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load extractor: picks byte/half/word from the raw memory word and extends it.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: kind (load type), off (byte offset ALU[1:0]), raw (aligned DM word),
//        data (extended load result).
module dm_load_ext
  import mips_defs::*;
(
  input  ld_kind_t    kind,
  input  logic [1:0]  off,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misaligned halfword/word offsets are not trapped here: the half select
  // simply ignores off[0] and a word load ignores off entirely.
  always_comb begin
    byte_sel = 8'(raw >> {off, 3'b000});
    half_sel = 16'(raw >> {off[1], 4'b0000});
    case (kind)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'd0, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data = {16'd0, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Write-back select + 32x32 GPR file with write-through read bypass, retire trace and counter.
// Latency: WD_W/WE_W/RD1/RD2 combinational; register commit, trace and counter 1 edge.
// Backpressure: none; one instruction accepted per cycle, Instr_W==0 is a bubble.
// Ports: clk, reset (async active-low); MEM/WB inputs Instr_W, ALU_W, DM_W, EXT_W,
//        PC8_W, WBA_W; read ports A1/A2 -> RD1/RD2; forwarding WD_W/WE_W;
//        trace tr_valid/tr_pc/tr_reg/tr_data; retired instruction count.
module wb_grf
  import mips_defs::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   Instr_W,
  input  logic [DW-1:0] ALU_W,
  input  logic [DW-1:0] DM_W,
  input  logic [DW-1:0] EXT_W,
  input  logic [31:0]   PC8_W,
  input  logic [4:0]    WBA_W,
  input  logic [4:0]    A1,
  input  logic [4:0]    A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic [DW-1:0] WD_W,
  output logic          WE_W,
  output logic          tr_valid,
  output logic [31:0]   tr_pc,
  output logic [4:0]    tr_reg,
  output logic [DW-1:0] tr_data,
  output logic [31:0]   retired
);

  logic [5:0]    op;
  logic [5:0]    fn;
  logic          writes;
  wb_src_t       src;
  ld_kind_t      kind;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] grf [NREG];
  logic [31:0]   retired_q;

  assign op = Instr_W[31:26];
  assign fn = Instr_W[5:0];

  always_comb begin
    writes = 1'b0;
    src    = WB_ALU;
    kind   = LD_W;
    case (op)
      OP_RTYPE: begin
        writes = rtype_writes(fn);
        if (fn == FN_JALR) src = WB_PC8;
      end
      OP_JAL:   begin writes = 1'b1; src = WB_PC8; end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI: writes = 1'b1;
      OP_LUI:   begin writes = 1'b1; src = WB_EXT; end
      OP_LB:    begin writes = 1'b1; src = WB_DM; kind = LD_B;  end
      OP_LBU:   begin writes = 1'b1; src = WB_DM; kind = LD_BU; end
      OP_LH:    begin writes = 1'b1; src = WB_DM; kind = LD_H;  end
      OP_LHU:   begin writes = 1'b1; src = WB_DM; kind = LD_HU; end
      OP_LW:    begin writes = 1'b1; src = WB_DM; kind = LD_W;  end
      default:  ;
    endcase
  end

  dm_load_ext u_ld (
    .kind (kind),
    .off  (ALU_W[1:0]),
    .raw  (DM_W),
    .data (ld_data)
  );

  always_comb begin
    case (src)
      WB_DM:   WD_W = ld_data;
      WB_EXT:  WD_W = EXT_W;
      WB_PC8:  WD_W = PC8_W;
      default: WD_W = ALU_W;
    endcase
  end

  // The all-zero word decodes as sll $0; it is excluded explicitly so a
  // bubble can never commit even if WBA_W carries a stale nonzero value.
  assign WE_W = writes && (Instr_W != 32'd0) && (WBA_W != 5'd0);

  // Write-through bypass so decode sees a value being committed this edge.
  always_comb begin
    if (A1 == 5'd0)                 RD1 = '0;
    else if (WE_W && A1 == WBA_W)   RD1 = WD_W;
    else                            RD1 = grf[A1];
    if (A2 == 5'd0)                 RD2 = '0;
    else if (WE_W && A2 == WBA_W)   RD2 = WD_W;
    else                            RD2 = grf[A2];
  end

  // Entry 0 is reset and never written because WE_W excludes WBA_W==0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) grf[i] <= '0;
    end else if (WE_W) begin
      grf[WBA_W] <= WD_W;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tr_valid  <= 1'b0;
      tr_pc     <= '0;
      tr_reg    <= '0;
      tr_data   <= '0;
      retired_q <= '0;
    end else begin
      tr_valid <= (Instr_W != 32'd0);
      tr_pc    <= PC8_W - 32'd8;
      tr_reg   <= WE_W ? WBA_W : 5'd0;
      tr_data  <= WE_W ? WD_W : '0;
      if (Instr_W != 32'd0) retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_wb_grf.sv
// Bench for wb_grf: scoreboard of expected trace records plus shadow register model.
// Latency: trace/counter checked one edge after issue; reads checked same cycle.
// Backpressure: none.
module tb_wb_grf;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] d;
  } tr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instr_W = '0, ALU_W = '0, DM_W = '0, EXT_W = '0, PC8_W = '0;
  logic [4:0]  WBA_W = '0, A1 = '0, A2 = '0;
  logic [31:0] RD1, RD2, WD_W, tr_pc, tr_data, retired;
  logic        WE_W, tr_valid;
  logic [4:0]  tr_reg;

  int n_chk = 0;
  int n_err = 0;

  tr_t         exp_q[$];
  logic [31:0] shadow [32];
  logic [31:0] exp_ret = '0;

  localparam logic [31:0] I_ADDU = 32'h0022_4021;
  localparam logic [31:0] I_MULT = 32'h0022_0018;
  localparam logic [31:0] I_JALR = 32'h0020_F809;
  localparam logic [31:0] I_JAL  = 32'h0C00_0100;
  localparam logic [31:0] I_LUI  = 32'h3C09_ABCD;
  localparam logic [31:0] I_LB   = 32'h8022_0003;
  localparam logic [31:0] I_LH   = 32'h8422_0002;
  localparam logic [31:0] I_LW   = 32'h8C22_0000;
  localparam logic [31:0] I_LBU  = 32'h9022_0003;
  localparam logic [31:0] I_LHU  = 32'h9422_0002;
  localparam logic [31:0] I_ORI  = 32'h3422_0007;

  wb_grf dut (
    .clk(clk), .reset(reset),
    .Instr_W(Instr_W), .ALU_W(ALU_W), .DM_W(DM_W), .EXT_W(EXT_W),
    .PC8_W(PC8_W), .WBA_W(WBA_W), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .WD_W(WD_W), .WE_W(WE_W),
    .tr_valid(tr_valid), .tr_pc(tr_pc), .tr_reg(tr_reg), .tr_data(tr_data),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] a, input logic we,
                                            input logic [4:0] wba, input logic [31:0] wd);
    if (a == 5'd0)           return 32'd0;
    else if (we && a == wba) return wd;
    else                     return shadow[a];
  endfunction

  // Drive one W-stage instruction at the falling edge, check the combinational
  // outputs, push the expected trace, then check trace and counter after the edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] ext, input logic [31:0] pc8, input logic [4:0] wba,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic we_exp, input logic [31:0] wd_exp);
    tr_t e, o;
    @(negedge clk);
    Instr_W = instr; ALU_W = alu; DM_W = dm; EXT_W = ext; PC8_W = pc8; WBA_W = wba;
    A1 = a1; A2 = a2;
    #1;
    chk("we", {31'd0, WE_W}, {31'd0, we_exp});
    if (we_exp) chk("wd", WD_W, wd_exp);
    chk("rd1", RD1, rd_model(a1, we_exp, wba, wd_exp));
    chk("rd2", RD2, rd_model(a2, we_exp, wba, wd_exp));
    e.v  = (instr != 32'd0);
    e.pc = pc8 - 32'd8;
    e.r  = we_exp ? wba : 5'd0;
    e.d  = we_exp ? wd_exp : 32'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (we_exp) shadow[wba] = wd_exp;
    if (instr != 32'd0) exp_ret = exp_ret + 32'd1;
    o = exp_q.pop_front();
    chk("tr_valid", {31'd0, tr_valid}, {31'd0, o.v});
    chk("tr_pc", tr_pc, o.pc);
    chk("tr_reg", {27'd0, tr_reg}, {27'd0, o.r});
    chk("tr_data", tr_data, o.d);
    chk("retired", retired, exp_ret);
  endtask

  task automatic bubble(input logic [4:0] a1, input logic [4:0] a2);
    issue(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, a1, a2, 1'b0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // Reset held across edges: registered outputs stay clear.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tr_valid", {31'd0, tr_valid}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_tr_pc", tr_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Every register reads zero after reset.
    for (int i = 0; i < 32; i++) bubble(5'(i), 5'(31 - i));

    // addu r8 with same-cycle bypass, then array read next cycle.
    issue(I_ADDU, 32'h1234, 32'd0, 32'd0, 32'h0000_1008, 5'd8, 5'd8, 5'd0, 1'b1, 32'h1234);
    bubble(5'd8, 5'd8);

    // Load extension, including the truncated misaligned cases.
    issue(I_LB,  32'h0000_0103, 32'h80FF_0102, 32'd0, 32'h2008, 5'd10, 5'd10, 5'd8, 1'b1, 32'hFFFF_FF80);
    issue(I_LBU, 32'h0000_0103, 32'h80FF_0102, 32'd0, 32'h200C, 5'd11, 5'd10, 5'd11, 1'b1, 32'h0000_0080);
    issue(I_LH,  32'h0000_0102, 32'h80FF_0102, 32'd0, 32'h2010, 5'd12, 5'd12, 5'd11, 1'b1, 32'hFFFF_80FF);
    issue(I_LHU, 32'h0000_0102, 32'h80FF_0102, 32'd0, 32'h2014, 5'd12, 5'd12, 5'd10, 1'b1, 32'h0000_80FF);
    issue(I_LH,  32'h0000_0103, 32'h80FF_0102, 32'd0, 32'h2018, 5'd15, 5'd15, 5'd12, 1'b1, 32'hFFFF_80FF);
    issue(I_LW,  32'h0000_0101, 32'h80FF_0102, 32'd0, 32'h201C, 5'd16, 5'd16, 5'd15, 1'b1, 32'h80FF_0102);
    issue(I_LB,  32'h0000_0101, 32'h80FF_0102, 32'd0, 32'h2020, 5'd17, 5'd16, 5'd17, 1'b1, 32'h0000_0001);

    // jal / jalr / lui / I-type ALU.
    issue(I_JAL,  32'h5555, 32'd0, 32'd0, 32'h0000_3008, 5'd31, 5'd31, 5'd9, 1'b1, 32'h0000_3008);
    issue(I_LUI,  32'h5555, 32'd0, 32'hABCD_0000, 32'h300C, 5'd9, 5'd31, 5'd9, 1'b1, 32'hABCD_0000);
    issue(I_JALR, 32'h5555, 32'd0, 32'd0, 32'h0000_4010, 5'd18, 5'd9, 5'd31, 1'b1, 32'h0000_4010);
    issue(I_ORI,  32'h0000_0077, 32'd0, 32'd0, 32'h4014, 5'd19, 5'd18, 5'd19, 1'b1, 32'h0000_0077);

    // Write to r0 dropped but still retires; mult writes nothing.
    issue(I_ADDU, 32'd5, 32'd0, 32'd0, 32'h5008, 5'd0, 5'd0, 5'd8, 1'b0, 32'd0);
    issue(I_MULT, 32'h9999, 32'd0, 32'd0, 32'h500C, 5'd8, 5'd8, 5'd0, 1'b0, 32'd0);

    // Both read ports bypass the same register.
    issue(I_ADDU, 32'hDEAD, 32'd0, 32'd0, 32'h5010, 5'd13, 5'd13, 5'd13, 1'b1, 32'hDEAD);
    bubble(5'd13, 5'd31);

    // Counter wrap from all-ones.
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    exp_ret = 32'hFFFF_FFFF;
    issue(I_ADDU, 32'h1, 32'd0, 32'd0, 32'h6008, 5'd20, 5'd20, 5'd0, 1'b1, 32'h1);

    // Three retirements interleaved with two bubbles.
    issue(I_ADDU, 32'h2, 32'd0, 32'd0, 32'h600C, 5'd21, 5'd20, 5'd21, 1'b1, 32'h2);
    bubble(5'd21, 5'd20);
    issue(I_MULT, 32'h3, 32'd0, 32'd0, 32'h6010, 5'd22, 5'd22, 5'd0, 1'b0, 32'd0);
    bubble(5'd22, 5'd0);
    issue(I_ADDU, 32'h4, 32'd0, 32'd0, 32'h6014, 5'd23, 5'd23, 5'd21, 1'b1, 32'h4);
    chk("retired_3", retired, 32'd3);

    // Reset dropped between edges with a write in flight.
    @(negedge clk);
    Instr_W = I_ADDU; ALU_W = 32'h77; PC8_W = 32'h7008; WBA_W = 5'd14;
    A1 = 5'd8; A2 = 5'd14;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_tr_valid", {31'd0, tr_valid}, 32'd0);
    chk("mid_tr_pc", tr_pc, 32'd0);
    chk("mid_tr_reg", {27'd0, tr_reg}, 32'd0);
    chk("mid_tr_data", tr_data, 32'd0);
    chk("mid_retired", retired, 32'd0);
    chk("mid_rd1_r8", RD1, 32'd0);
    @(posedge clk);
    #1;
    chk("hold_tr_valid", {31'd0, tr_valid}, 32'd0);
    chk("hold_retired", retired, 32'd0);
    @(negedge clk);
    Instr_W = 32'd0;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    exp_ret = '0;
    bubble(5'd14, 5'd8);
    bubble(5'd31, 5'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
